// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stall, branch redirect flush, load-wait freeze
// and EX operand forwarding select. Define PIPE_FWD_EN to compile in forwarding.
module pipe_hazard_ctrl #(
    parameter int RF_ADDRESS = 5,
    parameter int LOAD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [RF_ADDRESS-1:0] id_rs1,
    input  logic [RF_ADDRESS-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [RF_ADDRESS-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  ex_redirect,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall
);
    localparam int CLOG = $clog2(LOAD_LAT + 1);
    localparam int CW   = (CLOG > 1) ? CLOG : 1;

    logic                  ex_valid, ex_regwrite, ex_memread;
    logic [RF_ADDRESS-1:0] ex_rd;
    logic                  mem_valid, mem_regwrite, mem_memread;
    logic [RF_ADDRESS-1:0] mem_rd;
    logic                  wb_valid, wb_regwrite;
    logic [RF_ADDRESS-1:0] wb_rd;
    logic [CW-1:0]         wait_cnt;

    logic ex_prod, mem_prod, wb_prod;
    logic freeze, hazard;

`ifdef PIPE_FWD_EN
    logic [RF_ADDRESS-1:0] ex_rs1, ex_rs2;
    logic                  ex_rs1_used, ex_rs2_used;
`endif

    function automatic logic hit(input logic prod, input logic [RF_ADDRESS-1:0] rd,
                                 input logic used, input logic [RF_ADDRESS-1:0] src);
        return prod & used & (rd == src);
    endfunction

    // Only a valid, register-writing record with a non-zero destination can produce a value.
    assign ex_prod  = ex_valid  & ex_regwrite  & (ex_rd  != '0);
    assign mem_prod = mem_valid & mem_regwrite & (mem_rd != '0);
    assign wb_prod  = wb_valid  & wb_regwrite  & (wb_rd  != '0);

    generate
        if (LOAD_LAT == 0) begin : g_no_wait
            assign freeze = 1'b0;
        end else begin : g_wait
            assign freeze = mem_valid & mem_memread & (wait_cnt < CW'(LOAD_LAT));
        end
    endgenerate

`ifdef PIPE_FWD_EN
    assign hazard = id_valid & ex_memread &
                    (hit(ex_prod, ex_rd, id_rs1_used, id_rs1) |
                     hit(ex_prod, ex_rd, id_rs2_used, id_rs2));

    // MEM stage is younger than WB, so its result wins when both match.
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (ex_valid) begin
            if (hit(mem_prod, mem_rd, ex_rs1_used, ex_rs1))
                forward_a = 2'b10;
            else if (hit(wb_prod, wb_rd, ex_rs1_used, ex_rs1))
                forward_a = 2'b01;
            if (hit(mem_prod, mem_rd, ex_rs2_used, ex_rs2))
                forward_b = 2'b10;
            else if (hit(wb_prod, wb_rd, ex_rs2_used, ex_rs2))
                forward_b = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rs1_used <= 1'b0;
            ex_rs2_used <= 1'b0;
        end else if (!freeze) begin
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rs1_used <= id_rs1_used;
            ex_rs2_used <= id_rs2_used;
        end
    end
`else
    // No bypass network: any in-flight producer of a used source holds ID until it retires.
    assign hazard = id_valid &
                    (hit(ex_prod,  ex_rd,  id_rs1_used, id_rs1) |
                     hit(ex_prod,  ex_rd,  id_rs2_used, id_rs2) |
                     hit(mem_prod, mem_rd, id_rs1_used, id_rs1) |
                     hit(mem_prod, mem_rd, id_rs2_used, id_rs2) |
                     hit(wb_prod,  wb_rd,  id_rs1_used, id_rs1) |
                     hit(wb_prod,  wb_rd,  id_rs2_used, id_rs2));
    assign forward_a = 2'b00;
    assign forward_b = 2'b00;
`endif

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        stall        = 1'b0;
        if (reset) begin
            if (freeze) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
                stall     = 1'b1;
            end else if (ex_redirect) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (hazard) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
                stall        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
            wait_cnt     <= '0;
        end else if (freeze) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt     <= '0;
            wb_valid     <= mem_valid;
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            ex_valid     <= id_valid & ~id_ex_bubble;
            ex_rd        <= id_rd;
            ex_regwrite  <= id_regwrite;
            ex_memread   <= id_memread;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_LAT 0 and 3) share stimulus and are
// compared against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread, ex_redirect;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic [1:0] pc_w, ifid_w, idex_w, exmem_w, memwb_w, flush_w, bub_w, stall_w;
    logic [1:0] fa_w [2];
    logic [1:0] fb_w [2];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RF_ADDRESS(AW), .LOAD_LAT(0)) u_lat0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_redirect(ex_redirect),
        .pc_en(pc_w[0]), .if_id_en(ifid_w[0]), .id_ex_en(idex_w[0]), .ex_mem_en(exmem_w[0]),
        .mem_wb_en(memwb_w[0]), .if_id_flush(flush_w[0]), .id_ex_bubble(bub_w[0]),
        .forward_a(fa_w[0]), .forward_b(fb_w[0]), .stall(stall_w[0]));

    pipe_hazard_ctrl #(.RF_ADDRESS(AW), .LOAD_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_redirect(ex_redirect),
        .pc_en(pc_w[1]), .if_id_en(ifid_w[1]), .id_ex_en(idex_w[1]), .ex_mem_en(exmem_w[1]),
        .mem_wb_en(memwb_w[1]), .if_id_flush(flush_w[1]), .id_ex_bubble(bub_w[1]),
        .forward_a(fa_w[1]), .forward_b(fb_w[1]), .stall(stall_w[1]));

    // Model: each stage slot holds an instruction (or nothing); one wait count per instance.
    typedef struct {
        logic          v;
        logic [AW-1:0] rd;
        logic          rw, mr;
        logic [AW-1:0] rs1, rs2;
        logic          u1, u2;
    } rec_t;

    rec_t m_ex [2];
    rec_t m_mem [2];
    rec_t m_wb [2];
    int   m_cnt [2];

    function automatic int lat(int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic rec_t id_rec();
        rec_t r;
        r.v = id_valid; r.rd = id_rd; r.rw = id_regwrite; r.mr = id_memread;
        r.rs1 = id_rs1; r.rs2 = id_rs2; r.u1 = id_rs1_used; r.u2 = id_rs2_used;
        return r;
    endfunction

    function automatic bit hits(rec_t p, logic [AW-1:0] src, logic used);
        return p.v && p.rw && (p.rd != 0) && used && (src == p.rd);
    endfunction

    function automatic bit freezing(int k);
        return m_mem[k].v && m_mem[k].mr && (m_cnt[k] < lat(k));
    endfunction

    function automatic bit hazard(int k);
        rec_t i = id_rec();
        if (!id_valid) return 1'b0;
`ifdef PIPE_FWD_EN
        return m_ex[k].mr && (hits(m_ex[k], i.rs1, i.u1) || hits(m_ex[k], i.rs2, i.u2));
`else
        return hits(m_ex[k], i.rs1, i.u1) || hits(m_ex[k], i.rs2, i.u2) ||
               hits(m_mem[k], i.rs1, i.u1) || hits(m_mem[k], i.rs2, i.u2) ||
               hits(m_wb[k], i.rs1, i.u1) || hits(m_wb[k], i.rs2, i.u2);
`endif
    endfunction

    function automatic logic [1:0] fwd(int k, logic [AW-1:0] src, logic used);
`ifdef PIPE_FWD_EN
        if (!m_ex[k].v || !used) return 2'b00;
        if (hits(m_mem[k], src, 1'b1)) return 2'b10;
        if (hits(m_wb[k], src, 1'b1)) return 2'b01;
`endif
        return 2'b00;
    endfunction

    // {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble, fwd_a, fwd_b, stall}
    function automatic logic [11:0] expv(int k);
        logic [1:0] fa, fb;
        fa = fwd(k, m_ex[k].rs1, m_ex[k].u1);
        fb = fwd(k, m_ex[k].rs2, m_ex[k].u2);
        if (!reset) return 12'hF80;
        if (freezing(k)) return {5'b00000, 2'b00, fa, fb, 1'b1};
        if (ex_redirect) return {5'b11111, 2'b11, fa, fb, 1'b0};
        if (hazard(k)) return {5'b00111, 2'b01, fa, fb, 1'b1};
        return {5'b11111, 2'b00, fa, fb, 1'b0};
    endfunction

    // A hazard overridden by a redirect leaves the stall flag open to interpretation.
    function automatic logic [11:0] msk(int k);
        if (reset && !freezing(k) && ex_redirect && hazard(k)) return 12'hFFE;
        return 12'hFFF;
    endfunction

    function automatic logic [11:0] obs(int k);
        return {pc_w[k], ifid_w[k], idex_w[k], exmem_w[k], memwb_w[k], flush_w[k], bub_w[k],
                fa_w[k], fb_w[k], stall_w[k]};
    endfunction

    task automatic step(int k);
        bit bub;
        if (freezing(k)) begin
            m_cnt[k]++;
        end else begin
            bub = ex_redirect || hazard(k);
            m_cnt[k] = 0;
            m_wb[k]  = m_mem[k];
            m_mem[k] = m_ex[k];
            m_ex[k]  = id_rec();
            m_ex[k].v = id_valid && !bub;
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_ex[k].v = 1'b0; m_mem[k].v = 1'b0; m_wb[k].v = 1'b0; m_cnt[k] = 0;
        end
    endtask

    task automatic tick();
        if (reset) for (int k = 0; k < 2; k++) step(k);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int rs1, input logic u1, input int rs2,
                         input logic u2, input int rd, input logic rw, input logic mr,
                         input logic redir);
        id_valid = v; id_rs1 = AW'(rs1); id_rs1_used = u1; id_rs2 = AW'(rs2);
        id_rs2_used = u2; id_rd = AW'(rd); id_regwrite = rw; id_memread = mr;
        ex_redirect = redir;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain(int n);
        idle();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m_reset();
        drive(1, 1, 1, 2, 1, 3, 1, 1, 1);
        #2;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs(k) !== 12'hF80) begin
                n_fail++;
                $display("FAIL reset_outputs inst%0d got %b want %b", k, obs(k), 12'hF80);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL reset_held inst%0d got %b want %b", k, obs(k), expv(k));
            end
        end
        reset = 1'b1;
        idle();
    endtask

    task automatic test_forward();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        drive(1, 5, 1, 0, 0, 8, 1, 0, 0);
        #2;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL fwd_id_cycle inst%0d got %b want %b", k, obs(k), expv(k));
            end
        end
        n_chk++;
`ifdef PIPE_FWD_EN
        if (stall_w[0] !== 1'b0) begin
`else
        if (stall_w[0] !== 1'b1) begin
`endif
            n_fail++;
            $display("FAIL fwd_stall got %b", stall_w[0]);
        end
        tick();
        idle();
        #2;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL fwd_ex_cycle inst%0d got %b want %b", k, obs(k), expv(k));
            end
        end
        n_chk++;
`ifdef PIPE_FWD_EN
        if (fa_w[0] !== 2'b10) begin
`else
        if (fa_w[0] !== 2'b00) begin
`endif
            n_fail++;
            $display("FAIL fwd_a_mem got %b", fa_w[0]);
        end
        drain(5);
    endtask

    task automatic test_load_use();
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c < 2) drive(1, 0, 0, 6, 1, 9, 1, 0, 0);
            else idle();
            #2;
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if (obs(k) !== expv(k)) begin
                    n_fail++;
                    $display("FAIL load_use_c%0d inst%0d got %b want %b", c, k, obs(k), expv(k));
                end
            end
            if (c == 0) begin
                n_chk++;
                if ({stall_w[0], bub_w[0], pc_w[0]} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL load_use_stall got %b want 110", {stall_w[0], bub_w[0], pc_w[0]});
                end
            end
`ifdef PIPE_FWD_EN
            if (c == 1) begin
                n_chk++;
                if (stall_w[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_use_one_cycle got %b want 0", stall_w[0]);
                end
            end
            if (c == 2) begin
                n_chk++;
                if (fb_w[0] !== 2'b01) begin
                    n_fail++;
                    $display("FAIL load_use_fwd_b got %b want 01", fb_w[0]);
                end
            end
`endif
            tick();
        end
        drain(8);
    endtask

    task automatic test_freeze();
        int  frz = 0;
        bit  done = 0;
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        idle();
        tick();
        for (int i = 0; i < 10 && !done; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, (i == 1));
            #2;
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if ((obs(k) & msk(k)) !== (expv(k) & msk(k))) begin
                    n_fail++;
                    $display("FAIL freeze_i%0d inst%0d got %b want %b", i, k, obs(k), expv(k));
                end
            end
            if (i == 1) begin
                n_chk++;
                if (flush_w[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL freeze_redirect_ignored flush got %b want 0", flush_w[1]);
                end
            end
            if ({pc_w[1], ifid_w[1], idex_w[1], exmem_w[1], memwb_w[1]} === 5'b00000) begin
                frz++;
            end else begin
                done = 1;
                n_chk++;
                if ({pc_w[1], ifid_w[1], idex_w[1], exmem_w[1], memwb_w[1], stall_w[1]} !== 6'b111110) begin
                    n_fail++;
                    $display("FAIL freeze_release got %b want 111110",
                             {pc_w[1], ifid_w[1], idex_w[1], exmem_w[1], memwb_w[1], stall_w[1]});
                end
            end
            tick();
        end
        n_chk++;
        if (frz != 3 || !done) begin
            n_fail++;
            $display("FAIL freeze_length got %0d cycles (done=%0d) want 3", frz, done);
        end
        drain(4);
    endtask

    task automatic test_redirect();
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
        tick();
        drive(1, 6, 1, 0, 0, 9, 1, 0, 1);
        #2;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if ({flush_w[k], bub_w[k], pc_w[k]} !== 3'b111) begin
                n_fail++;
                $display("FAIL redirect_prio inst%0d got %b want 111", k, {flush_w[k], bub_w[k], pc_w[k]});
            end
            n_chk++;
            if ((obs(k) & msk(k)) !== (expv(k) & msk(k))) begin
                n_fail++;
                $display("FAIL redirect_vec inst%0d got %b want %b", k, obs(k), expv(k));
            end
        end
        tick();
        drive(1, 0, 0, 0, 0, 3, 0, 0, 0);
        #2;
        n_chk++;
        if (stall_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_next_nostall got %b want 0", stall_w[0]);
        end
        tick();
        drain(6);
    endtask

    task automatic test_x0();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 0, 1, 0, 1, 4, 1, 0, 0);
        #2;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (stall_w[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL x0_nostall inst%0d got %b want 0", k, stall_w[k]);
            end
        end
        tick();
        drive(1, 0, 1, 0, 0, 0, 1, 1, 0);
        #2;
        n_chk++;
        if (fa_w[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL x0_fwd_a got %b want 00", fa_w[0]);
        end
        tick();
        drive(1, 0, 1, 0, 1, 2, 1, 0, 0);
        #2;
        n_chk++;
        if (stall_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_load_nostall got %b want 0", stall_w[0]);
        end
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL x0_vec inst%0d got %b want %b", k, obs(k), expv(k));
            end
        end
        tick();
        drain(6);
    endtask

    task automatic test_reset_mid_freeze();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        idle();
        tick();
        tick();
        #2;
        n_chk++;
        if (stall_w[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_freeze_pre got %b want 1", stall_w[1]);
        end
        reset = 1'b0;
        m_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs(k) !== 12'hF80) begin
                n_fail++;
                $display("FAIL rst_freeze_abandon inst%0d got %b want %b", k, obs(k), 12'hF80);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
        tick();
        drive(1, 0, 0, 6, 1, 9, 1, 0, 0);
        #2;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if ({stall_w[k], bub_w[k]} !== 2'b11) begin
                n_fail++;
                $display("FAIL rst_then_load_use inst%0d got %b want 11", k, {stall_w[k], bub_w[k]});
            end
        end
        tick();
        drain(8);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            #2;
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if ((obs(k) & msk(k)) !== (expv(k) & msk(k))) begin
                    n_fail++;
                    $display("FAIL random_c%0d inst%0d got %b want %b", c, k, obs(k), expv(k));
                end
            end
            tick();
        end
        drain(6);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        m_reset();
        #1;
        test_reset();
        test_forward();
        test_load_use();
        test_freeze();
        test_redirect();
        test_x0();
        test_reset_mid_freeze();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter RF_ADDRESS, default 5, register-file address width.
REQ-002 Parameter LOAD_LAT, default 1, extra data-memory wait cycles per load; legal range 0..7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 id_valid  input  1  IF/ID register holds a live instruction.
REQ-006 id_rs1, id_rs2  input  RF_ADDRESS  source registers of the ID instruction.
REQ-007 id_rs1_used, id_rs2_used  input  1  the corresponding source is actually read.
REQ-008 id_rd  input  RF_ADDRESS  destination of the ID instruction.
REQ-009 id_regwrite, id_memread  input  1  ID control bits (register write, load).
REQ-010 ex_redirect  input  1  EX resolved a taken branch, Jal or Jalr this cycle.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1  pipeline-register load enables.
REQ-012 if_id_flush, id_ex_bubble  output  1  clear IF/ID, or load a NOP into ID/EX.
REQ-013 forward_a, forward_b  output  2  EX operand select: 00 register file, 01 WB data, 10 EX/MEM ALU result.
REQ-014 stall  output  1  OR of load-use stall, RAW stall and memory freeze.

Function
REQ-015 Block shall keep shadow records for EX, MEM and WB: valid, rd, regwrite, memread. EX also keeps rs1/rs2 with their used bits.
REQ-016 A record is a producer only if valid=1, regwrite=1 and rd!=0; non-producers never match.
REQ-017 Freeze condition: MEM record valid with memread=1 and wait counter < LOAD_LAT.
REQ-018 During freeze, all enables shall be 0, all records and the counter hold except the counter increment, and ex_redirect shall be ignored.
REQ-019 Wait counter shall clear to 0 whenever MEM advances; width max(1, clog2(LOAD_LAT+1)); LOAD_LAT=0 shall never freeze.
REQ-020 Load-use stall: EX producer with memread=1 whose rd equals a used ID source while id_valid=1.
REQ-021 On load-use stall (no freeze): pc_en=0, if_id_en=0, id_ex_bubble=1; EX, MEM and WB advance.
REQ-022 On ex_redirect (no freeze): if_id_flush=1, id_ex_bubble=1, pc_en=1; redirect takes priority over load-use and RAW stalls.
REQ-023 Normal advance: WB<=MEM, MEM<=EX, EX<=ID record. EX is loaded invalid on bubble or when id_valid=0.
REQ-024 forward_a/b shall be combinational from the EX record: 10 if a MEM producer rd matches, else 01 if a WB producer rd matches, else 00; MEM has priority.
REQ-025 Forward output shall be 00 when the EX record is invalid or that source is unused.
REQ-026 All outputs other than forward_a/b, which follow REQ-024/025, shall be combinational from current state and inputs with zero latency; enables default to 1.

Reset
REQ-027 Asserting reset shall immediately clear all record valid bits and the wait counter.
REQ-028 While reset is low, outputs shall be pc_en=if_id_en=id_ex_en=ex_mem_en=mem_wb_en=1, if_id_flush=0, id_ex_bubble=0, forward_a=forward_b=00, stall=0.
REQ-029 Reset asserted mid-freeze or mid-stall shall abandon it; the first edge after release shall behave as a normal advance.

Configuration
REQ-030 Macro PIPE_FWD_EN: when defined, forwarding per REQ-024/025 is compiled in.
REQ-031 Without PIPE_FWD_EN, forward_a/b shall be tied 00. Any used ID source matching an EX, MEM or WB producer shall raise a RAW stall, with the same action as REQ-021; this replaces the load-use-only check.

Verification
REQ-032 add x5 in EX, then add using rs1=x5 in ID, PIPE_FWD_EN -> next cycle forward_a=10, stall=0.
REQ-033 lw x6 in EX, then ID uses rs2=x6, LOAD_LAT=0 -> stall=1 and id_ex_bubble=1 for one cycle; two cycles later forward_b=01.
REQ-034 lw in MEM, LOAD_LAT=3 -> all enables 0 for exactly 3 cycles, then one normal advance.
REQ-035 ex_redirect=1 together with a load-use condition -> if_id_flush=1, id_ex_bubble=1, pc_en=1 in that cycle, and no stall the next cycle.
REQ-036 Producer rd=x0 matching ID rs1=x0 -> forward_a=00 and stall=0.
REQ-037 reset low during the 2nd freeze cycle -> stall=0 at once; after release a lw/use pair behaves per REQ-033.
